// File: rtl/ccff_loader_pkg.sv
// -----------------------------------------------------------------------------
// ccff_loader_pkg
// Shared definitions for the ccff chain loader: default chain/word geometry,
// the loader FSM state encoding and small elaboration-time helpers used to
// size the word/bit counters.
// -----------------------------------------------------------------------------
package ccff_loader_pkg;

  // One ble4: 16 LUT bits plus 2 output-mux bits.
  localparam int CHAIN_LEN_DEF = 18;
  localparam int WORD_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of bitstream words needed to cover the whole chain.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Bits actually used from the final word (a full word when the chain
  // length is an exact multiple of the word width).
  function automatic int last_word_bits(input int chain_len, input int word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// -----------------------------------------------------------------------------
// ccff_rb_packer
// Collects the bits leaving the chain tail into a readback accumulator (LSB
// first) and hands completed words to a one-entry valid/ready output register.
// The final word of a load is flagged as complete once CHAIN_LEN bits have
// been captured; its unused upper bits read as zero.
//
// Ports
//   prog_clk  in   clock, rising edge
//   reset     in   synchronous active-high reset
//   clear     in   synchronous flush at load start / abort
//   bit_valid in   capture bit_in this cycle (chain is shifting)
//   bit_in    in   chain tail bit
//   acc_full  out  accumulator holds a complete word; no bit may be captured
//   rb_valid  out  / rb_ready in / rb_data out : readback stream
//   final_hs  out  last readback word of the load is handshaking this cycle
// -----------------------------------------------------------------------------
module ccff_rb_packer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              acc_full,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              final_hs
);

  localparam int BCW = $clog2(WORD_W + 1);
  localparam int SCW = $clog2(CHAIN_LEN + 1);

  logic [WORD_W-1:0] acc_q;
  logic [BCW-1:0]    acc_cnt_q;
  logic [SCW-1:0]    total_q;
  logic [WORD_W-1:0] out_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              all_in;
  logic              xfer;

  always_comb begin
    all_in   = (total_q == SCW'(CHAIN_LEN));
    // A partial final word counts as full once every chain bit is captured.
    acc_full = (acc_cnt_q == BCW'(WORD_W)) || (all_in && (acc_cnt_q != '0));
    // Move into the output register when it is empty or emptying this cycle.
    xfer     = acc_full && (!out_valid_q || rb_ready);
  end

  assign rb_valid = out_valid_q;
  assign rb_data  = out_q;
  assign final_hs = out_valid_q && rb_ready && out_last_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge prog_clk) begin
    if (reset || clear) begin
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      total_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (xfer) begin
      out_q       <= acc_q;
      out_valid_q <= 1'b1;
      out_last_q  <= all_in;
      // Clearing here gives the zero padding of a partial final word.
      acc_q       <= '0;
      acc_cnt_q   <= '0;
    end else begin
      if (out_valid_q && rb_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (bit_valid) begin
        acc_q     <= acc_q | (WORD_W'(bit_in) << acc_cnt_q);
        acc_cnt_q <= acc_cnt_q + BCW'(1);
        total_q   <= total_q + SCW'(1);
      end
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// -----------------------------------------------------------------------------
// ccff_loader
// Streams a configuration bitstream (WORD_W-bit words, LSB first) into a
// CHAIN_LEN-bit ccff scan chain while packing the bits that fall out of the
// tail into a readback word stream. Shifting stalls whenever no input bit is
// available or the readback side cannot accept another bit.
//
// Ports
//   prog_clk       in   clock, rising edge
//   reset          in   synchronous active-high reset
//   start          in   single-cycle load request (honoured in IDLE only)
//   abort          in   cancel any load in progress
//   cfg_valid/cfg_ready/cfg_data  bitstream input stream
//   rb_valid/rb_ready/rb_data     readback of previous chain contents
//   ccff_head      out  serial bit into the chain head
//   ccff_shift_en  out  chain advances at the end of each cycle it is high
//   ccff_tail      in   serial bit from the chain tail
//   busy           out  load in progress (SHIFT or DRAIN)
//   done           out  last load completed; held until the next start
// -----------------------------------------------------------------------------
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
);

  localparam int NUM_WORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
  localparam int BCW       = $clog2(WORD_W + 1);
  localparam int WCW       = $clog2(NUM_WORDS + 1);
  localparam int SCW       = $clog2(CHAIN_LEN + 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q;
  logic [BCW-1:0]    bits_left_q;
  logic [WCW-1:0]    words_taken_q;
  logic [SCW-1:0]    shift_cnt_q;
  logic              done_q;

  logic start_ok;
  logic cfg_xfer;
  logic last_word;
  logic last_shift;
  logic acc_full;
  logic final_hs;

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    start_ok   = (state_q == ST_IDLE) && start && !abort;
    last_word  = (words_taken_q == WCW'(NUM_WORDS - 1));
    last_shift = (shift_cnt_q == SCW'(CHAIN_LEN - 1));
    // Abort gates both handshakes so no word is consumed into a dead load.
    cfg_ready  = (state_q == ST_SHIFT) && (bits_left_q == '0) &&
                 (words_taken_q != WCW'(NUM_WORDS)) && !abort;
    ccff_shift_en = (state_q == ST_SHIFT) && (bits_left_q != '0) &&
                    !acc_full && !abort;
    cfg_xfer   = cfg_valid && cfg_ready;
  end

  assign ccff_head = (bits_left_q != '0) && word_q[0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)                         state_d = ST_SHIFT;
      ST_SHIFT: if (ccff_shift_en && last_shift)   state_d = ST_DRAIN;
      ST_DRAIN: if (final_hs)                      state_d = ST_IDLE;
      default:                                     state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge prog_clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Word register and load counters. A word is only loaded once the previous
  // one is fully shifted, so load and shift never coincide.
  always_ff @(posedge prog_clk) begin
    if (reset || abort || start_ok) begin
      word_q        <= '0;
      bits_left_q   <= '0;
      words_taken_q <= '0;
      shift_cnt_q   <= '0;
    end else if (cfg_xfer) begin
      word_q        <= cfg_data;
      bits_left_q   <= last_word ? BCW'(LAST_BITS) : BCW'(WORD_W);
      words_taken_q <= words_taken_q + WCW'(1);
    end else if (ccff_shift_en) begin
      word_q        <= word_q >> 1;
      bits_left_q   <= bits_left_q - BCW'(1);
      shift_cnt_q   <= shift_cnt_q + SCW'(1);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (reset || abort || start_ok)             done_q <= 1'b0;
    else if ((state_q == ST_DRAIN) && final_hs) done_q <= 1'b1;
  end

  ccff_rb_packer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_rb_packer (
    .prog_clk  (prog_clk),
    .reset     (reset),
    .clear     (abort || start_ok),
    .bit_valid (ccff_shift_en),
    .bit_in    (ccff_tail),
    .acc_full  (acc_full),
    .rb_valid  (rb_valid),
    .rb_ready  (rb_ready),
    .rb_data   (rb_data),
    .final_hs  (final_hs)
  );

endmodule

// File: tb/tb_ccff_loader.sv
// -----------------------------------------------------------------------------
// tb_ccff_loader
// Self-checking bench: an 18-bit behavioural chain model on ccff_head/tail,
// a cfg word driver with optional idle gaps, and a readback scoreboard filled
// from the chain preload pattern when each load starts.
// -----------------------------------------------------------------------------
module tb_ccff_loader;
  import ccff_loader_pkg::*;

  localparam int CL = 18;
  localparam int WW = 8;
  localparam int NW = 3;
  localparam logic [CL-1:0] PRELOAD = 18'h2AAAA; // tail emits 1,0,1,0...

  logic          prog_clk = 1'b0;
  logic          reset, start, abort;
  logic          cfg_valid, cfg_ready;
  logic [WW-1:0] cfg_data;
  logic          rb_valid, rb_ready;
  logic [WW-1:0] rb_data;
  logic          ccff_head, ccff_shift_en, ccff_tail;
  logic          busy, done;

  logic [CL-1:0] chain;
  assign ccff_tail = chain[CL-1];

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk      (prog_clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_data      (cfg_data),
    .rb_valid      (rb_valid),
    .rb_ready      (rb_ready),
    .rb_data       (rb_data),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          cfg_ready;
    logic          rb_valid;
    logic          shift_en;
    logic          head;
    logic [WW-1:0] rb_data;
  } snap_t;

  snap_t         snap;
  int            n_pass = 0;
  int            n_checks = 0;
  int            shifts = 0;
  int            word_idx = NW;
  int            gap_cnt = 0;
  int            gap = 0;
  logic [WW-1:0] words [NW] = '{8'hA5, 8'h3C, 8'h02};
  logic [WW-1:0] exp_q [$];
  logic          hold_valid = 1'b0;
  logic [WW-1:0] hold_data = '0;
  logic [CL-1:0] exp_chain;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Chain contents after a full load: the first bit shifted sits at the tail.
  function automatic logic [CL-1:0] model_chain();
    logic [CL-1:0] r;
    int pos;
    r = '0;
    pos = 0;
    for (int w = 0; w < NW; w++) begin
      for (int b = 0; b < ((w == NW - 1) ? (CL - WW * (NW - 1)) : WW); b++) begin
        r[CL-1-pos] = words[w][b];
        pos++;
      end
    end
    return r;
  endfunction

  // Readback word w: tail bits in emission order, LSB first, zero padded.
  function automatic logic [WW-1:0] model_rb(input int w);
    logic [WW-1:0] r;
    logic [CL-1:0] pre;
    pre = PRELOAD;
    r = '0;
    for (int b = 0; b < WW; b++)
      if (WW * w + b < CL) r[b] = pre[CL-1-(WW*w+b)];
    return r;
  endfunction

  // One clock: drive cfg, sample at negedge, then apply the chain shift
  // just after the rising edge (the DUT has already captured the old tail).
  task automatic cycle();
    logic sh, hd;
    if (word_idx < NW && gap_cnt == 0) begin
      cfg_valid = 1'b1;
      cfg_data  = words[word_idx];
    end else begin
      cfg_valid = 1'b0;
      cfg_data  = '0;
    end
    @(negedge prog_clk);
    snap = {busy, done, cfg_ready, rb_valid, ccff_shift_en, ccff_head, rb_data};
    sh = ccff_shift_en;
    hd = ccff_head;
    if (hold_valid) check("rb_hold", {23'd0, rb_valid, rb_data}, {23'd0, 1'b1, hold_data});
    hold_valid = (rb_valid === 1'b1) && !rb_ready;
    hold_data  = rb_data;
    if (rb_valid === 1'b1 && rb_ready) begin
      check("rb_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("rb_data", rb_data, exp_q.pop_front());
    end
    if (cfg_valid && cfg_ready === 1'b1) begin
      word_idx++;
      gap_cnt = gap;
    end else if (!cfg_valid && gap_cnt > 0) begin
      gap_cnt--;
    end
    @(posedge prog_clk);
    #1;
    if (sh === 1'b1) begin
      chain = {chain[CL-2:0], hd};
      shifts++;
    end
  endtask

  task automatic start_load();
    chain = PRELOAD;
    shifts = 0;
    word_idx = 0;
    gap_cnt = 0;
    hold_valid = 1'b0;
    exp_q.delete();
    for (int w = 0; w < NW; w++) exp_q.push_back(model_rb(w));
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
  endtask

  task automatic run_until_done(input string tag);
    int n;
    n = 0;
    while (snap.done !== 1'b1 && n < 400) begin
      cycle();
      n++;
    end
    check({tag, "_done"}, 32'(snap.done), 1);
  endtask

  task automatic check_load(input string tag);
    check({tag, "_shifts"}, shifts, CL);
    check({tag, "_chain"}, 32'(chain), 32'(exp_chain));
    check({tag, "_rb_left"}, exp_q.size(), 0);
    check({tag, "_busy"}, 32'(snap.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    exp_chain = model_chain();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0; rb_ready = 1'b1;
    chain = PRELOAD;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("rst_busy",  32'(snap.busy), 0);
    check("rst_done",  32'(snap.done), 0);
    check("rst_cfg_ready", 32'(snap.cfg_ready), 0);
    check("rst_rb_valid",  32'(snap.rb_valid), 0);
    check("rst_shift_en",  32'(snap.shift_en), 0);
    check("rst_head",  32'(snap.head), 0);

    // Baseline load, readback always accepted.
    start_load();
    check("a_busy", 32'(snap.busy), 1);
    run_until_done("a");
    check_load("a");

    // Readback back-pressure: stalls after two full readback words.
    rb_ready = 1'b0;
    start_load();
    repeat (60) cycle();
    check("b_stall_shifts", shifts, 16);
    check("b_stall_shift_en", 32'(snap.shift_en), 0);
    check("b_stall_rb_valid", 32'(snap.rb_valid), 1);
    check("b_stall_rb_data", snap.rb_data, exp_q[0]);
    check("b_stall_done", 32'(snap.done), 0);
    rb_ready = 1'b1;
    run_until_done("b");
    check_load("b");

    // Idle gaps between cfg words.
    gap = 5;
    start_load();
    run_until_done("c");
    check_load("c");
    gap = 0;

    // Abort after 10 shifts.
    start_load();
    n = 0;
    while (shifts < 10 && n < 200) begin cycle(); n++; end
    check("d_reach10", shifts, 10);
    word_idx = NW;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();
    check("d_busy", 32'(snap.busy), 0);
    check("d_done", 32'(snap.done), 0);
    check("d_shift_en", 32'(snap.shift_en), 0);
    check("d_cfg_ready", 32'(snap.cfg_ready), 0);
    check("d_rb_valid", 32'(snap.rb_valid), 0);
    check("d_shifts", shifts, 10);
    repeat (5) cycle();
    check("d_shifts_later", shifts, 10);
    exp_q.delete();

    // Abort wins over a simultaneous start.
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    cycle();
    check("abort_start_busy", 32'(snap.busy), 0);

    // Reset mid-load, then a fresh complete load.
    start_load();
    n = 0;
    while (shifts < 5 && n < 200) begin cycle(); n++; end
    check("e_reach5", shifts, 5);
    word_idx = NW;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("e_outputs", 32'(snap), 0);
    exp_q.delete();
    start_load();
    run_until_done("e");
    check_load("e");

    // Start during SHIFT is ignored; start after done clears done.
    start_load();
    n = 0;
    while (shifts < 4 && n < 200) begin cycle(); n++; end
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("f_busy_mid", 32'(snap.busy), 1);
    run_until_done("f1");
    check_load("f1");
    repeat (3) cycle();
    check("f_done_hold", 32'(snap.done), 1);
    check("f_idle_busy", 32'(snap.busy), 0);
    start_load();
    check("f_done_clear", 32'(snap.done), 0);
    check("f_busy_again", 32'(snap.busy), 1);
    run_until_done("f2");
    check_load("f2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The module SHALL have parameter CHAIN_LEN, default 18, meaning the number of configuration bits in the target ccff chain (one ble4: 16 LUT bits plus 2 output-mux bits).
REQ-002 The module SHALL have parameter WORD_W, default 8, meaning the bitstream and readback word width.
REQ-003 The module SHALL have port prog_clk  input  1  the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 The module SHALL have port abort  input  1  terminate any load in progress.
REQ-007 The module SHALL have ports cfg_valid  input  1 / cfg_ready  output  1 / cfg_data  input  WORD_W  bitstream word stream.
REQ-008 The module SHALL have ports rb_valid  output  1 / rb_ready  input  1 / rb_data  output  WORD_W  readback stream of the previous chain contents.
REQ-009 The module SHALL have port ccff_head  output  1  serial bit driven into the chain head.
REQ-010 The module SHALL have port ccff_shift_en  output  1  chain shift enable; the chain advances one position at the end of each cycle it is high.
REQ-011 The module SHALL have port ccff_tail  input  1  serial bit at the chain tail.
REQ-012 The module SHALL have ports busy  output  1 and done  output  1  status.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DRAIN; start in IDLE moves to SHIFT; start in SHIFT or DRAIN is ignored.
REQ-014 A load SHALL consume exactly ceil(CHAIN_LEN/WORD_W) words; cfg_ready is high only in SHIFT while the word register is empty and words remain; a word transfers on cfg_valid && cfg_ready.
REQ-015 Each word SHALL be shifted LSB first; for the final word only the low (CHAIN_LEN mod WORD_W) bits are used (all bits if zero) and the rest are discarded.
REQ-016 ccff_shift_en SHALL be high exactly CHAIN_LEN cycles per completed load, only in cycles where the word register holds an unshifted bit and the readback accumulator is not full.
REQ-017 In each cycle with ccff_shift_en high, ccff_tail SHALL be captured into the readback accumulator at the next free bit position, LSB first.
REQ-018 A full accumulator (WORD_W bits, or the final partial word zero-padded in upper bits) SHALL transfer to rb_data/rb_valid in the same cycle the output register is empty or draining (rb_valid && rb_ready); otherwise shifting stalls.
REQ-019 rb_data SHALL remain stable while rb_valid && !rb_ready.
REQ-020 After the CHAIN_LEN-th shift the FSM SHALL enter DRAIN and return to IDLE in the cycle the final readback word handshakes, setting done.
REQ-021 done SHALL stay high in IDLE until the next accepted start, which clears it in the following cycle; busy SHALL be high exactly in SHIFT and DRAIN.
REQ-022 abort SHALL deassert ccff_shift_en combinationally in its cycle and SHALL return the FSM to IDLE next cycle with done=0, rb_valid=0, cfg_ready=0 and all counters cleared; abort wins over a simultaneous start.
REQ-023 Input words absent (cfg_valid low) SHALL stall shifting without losing or duplicating bits.

Reset
REQ-024 Reset SHALL force IDLE and drive busy, done, cfg_ready, rb_valid, rb_data, ccff_head and ccff_shift_en to 0 on the next edge, overriding start and abort, including mid-load.

Structure
REQ-025 The FSM state encoding and default CHAIN_LEN/WORD_W SHALL live in a shared package ccff_loader_pkg.
REQ-026 The readback accumulator plus output register SHALL be one sub-module, ccff_rb_packer.

Verification
REQ-027 Bench chain model preloaded so the tail emits 1,0,1,0...; load 0xA5,0x3C,0x02 with rb_ready=1 -> exactly 18 shift_en cycles, rb_data 0x55,0x55,0x01, chain holds bits 0xA5,0x3C then 2'b10 in shift order, done=1.
REQ-028 Same load with rb_ready held low -> shifting stops after 16 shifts; raising rb_ready completes the remaining 2 shifts with identical data.
REQ-029 Five idle cycles inserted between each cfg word -> still exactly 18 shifts, identical chain contents and readback.
REQ-030 abort after 10 shifts -> next cycle busy=0, done=0, shift_en=0, cfg_ready=0, rb_valid=0; chain model shows exactly 10 shifts.
REQ-031 reset asserted after 5 shifts -> all outputs 0 next edge; a fresh start then performs a complete 18-shift load.
REQ-032 start pulsed during SHIFT -> ignored; start after done -> done clears next cycle and a new load runs.
